// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode/issue controller.
//   state_e   : controller FSM encoding (IDLE=0, DEC=1, CHK=2)
//   REG_X0    : architectural zero register index
//   idx_mask  : one-hot 32-bit mask for a 5-bit register index
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    CHK  = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One-hot select of a single scoreboard bit.
  function automatic logic [31:0] idx_mask(input logic [4:0] idx);
    idx_mask = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// reg_scoreboard: 32-entry pending-write scoreboard.
//   i_clk, i_rstn          : clock, synchronous active-low reset
//   i_set_en, i_set_idx    : mark a destination as write-pending
//   i_clr_en, i_clr_idx    : writeback retires a pending destination
//   i_rs1, i_rs2, i_rd     : read-port indices
//   o_busy_vec             : registered scoreboard
//   o_rs1/rs2/rd_busy      : read ports, already bypassed by this cycle's clear
module reg_scoreboard
  import decode_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_idx,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_idx,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  output logic [31:0] o_busy_vec,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_rd_busy
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic [31:0] w_busy_byp;
  logic [31:0] w_busy_nxt;

  // Clear is applied before set so a same-index set wins; bit 0 never holds a 1.
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (i_set_en && (i_set_idx != REG_X0)) begin
      w_set_mask = idx_mask(i_set_idx);
    end else begin
      w_set_mask = 32'd0;
    end
    if (i_clr_en && (i_clr_idx != REG_X0)) begin
      w_clr_mask = idx_mask(i_clr_idx);
    end else begin
      w_clr_mask = 32'd0;
    end
    w_busy_byp = r_busy & ~w_clr_mask;
    w_busy_nxt = (w_busy_byp | w_set_mask) & ~32'd1;
  end

  // Scoreboard state register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;
  // Reads see the writeback bypass so a retiring source unblocks issue this cycle.
  assign o_rs1_busy = w_busy_byp[i_rs1];
  assign o_rs2_busy = w_busy_byp[i_rs2];
  assign o_rd_busy  = w_busy_byp[i_rd];

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: single-slot fetch -> decode -> hazard check -> issue controller.
//   CLK, RSTN                     : clock, synchronous active-low reset
//   if_vld/if_inst/if_rdy         : fetch handshake
//   dec_en/dec_inst               : decode strobe and held instruction
//   dec_type_vld, rs*_ren, rd_wen,
//   rs1/rs2/rd                    : decoder results, sampled only in CHK
//   ex_rdy                        : execute stage can accept an issue
//   iss_vld/iss_rd                : issue pulse and destination
//   wb_vld/wb_rd                  : writeback retiring a pending destination
//   flush                         : drop the in-flight instruction
//   illegal                       : undecodable instruction pulse
//   stall_cnt                     : saturating count of stalled CHK cycles
//   busy_vec                      : scoreboard
module decode_issue_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int SCNT_W = 16,
  parameter int XLEN   = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              if_vld,
  input  logic [XLEN-1:0]   if_inst,
  output logic              if_rdy,
  output logic              dec_en,
  output logic [XLEN-1:0]   dec_inst,
  input  logic              dec_type_vld,
  input  logic              rs1_ren,
  input  logic              rs2_ren,
  input  logic              rd_wen,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic              ex_rdy,
  output logic              iss_vld,
  output logic [4:0]        iss_rd,
  input  logic              wb_vld,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic              illegal,
  output logic [SCNT_W-1:0] stall_cnt,
  output logic [31:0]       busy_vec
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [XLEN-1:0]   r_dec_inst;
  logic [SCNT_W-1:0] r_stall_cnt;

  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_rd_busy;
  logic w_in_chk;
  logic w_hazard;
  logic w_illegal;
  logic w_issue;
  logic w_stall;
  logic w_accept;
  logic w_capture;

  reg_scoreboard u_sb (
    .i_clk      (CLK),
    .i_rstn     (RSTN),
    .i_set_en   (w_issue && rd_wen),
    .i_set_idx  (rd),
    .i_clr_en   (wb_vld),
    .i_clr_idx  (wb_rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_rd       (rd),
    .o_busy_vec (busy_vec),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy)
  );

  // Issue decision; flush and reset suppress every CHK action.
  always_comb begin
    w_in_chk  = RSTN && !flush && (r_state == CHK);
    w_hazard  = (rs1_ren && (rs1 != REG_X0) && w_rs1_busy) ||
                (rs2_ren && (rs2 != REG_X0) && w_rs2_busy) ||
                (rd_wen  && (rd  != REG_X0) && w_rd_busy);
    w_illegal = w_in_chk && !dec_type_vld;
    w_issue   = w_in_chk && dec_type_vld && !w_hazard && ex_rdy;
    w_stall   = w_in_chk && dec_type_vld && (w_hazard || !ex_rdy);
    // The issuing cycle frees the slot, so fetch may refill it immediately.
    w_accept  = RSTN && !flush && ((r_state == IDLE) || w_issue);
    w_capture = w_accept && if_vld;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = if_vld ? DEC : IDLE;
        DEC:  w_state_nxt = CHK;
        CHK: begin
          if (!dec_type_vld) begin
            w_state_nxt = IDLE;
          end else if (w_stall) begin
            w_state_nxt = CHK;
          end else begin
            w_state_nxt = if_vld ? DEC : IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, held instruction and stall counter.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_dec_inst  <= {XLEN{1'b0}};
      r_stall_cnt <= {SCNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_dec_inst <= if_inst;
      end else begin
        r_dec_inst <= r_dec_inst;
      end
      if (w_stall && (r_stall_cnt != {SCNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign if_rdy    = w_accept;
  // DEC lasts exactly one cycle, so the strobe is the state itself, masked by flush.
  assign dec_en    = RSTN && !flush && (r_state == DEC);
  assign dec_inst  = r_dec_inst;
  assign iss_vld   = w_issue;
  assign iss_rd    = (w_issue && rd_wen) ? rd : 5'd0;
  assign illegal   = w_illegal;
  assign stall_cnt = r_stall_cnt;

endmodule
